music_box_sequencer: RTL and testbench

Playback controller for the music box. Steps through a song stored in a synchronous ROM, one entry per note, and holds each note for a programmed number of 1/32-second ticks. Drives the enable of the 1/32-second tick counter and consumes its one-cycle tick pulse. Presents the current note code to the tone/piano datapath and exposes play/pause/stop control to the user-input logic.

---
 rtl/music_box_sequencer.sv | 168 ++++++++++++++++
 tb/tb_music_box_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_box_sequencer.sv
`default_nettype none
// music_box_sequencer: walks a song ROM one entry per note, holding each note
// for its programmed number of 1/32 s ticks, optionally followed by a silent gap.
module music_box_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int NOTE_W    = 5,
  parameter int DUR_W     = 6,
  parameter int GAP_TICKS = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    pause,
  input  logic                    stop,
  input  logic                    tick_32,
  output logic                    tick_enable,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [NOTE_W+DUR_W-1:0] rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic                    note_on,
  output logic                    busy,
  output logic                    done
);

  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_TICKS);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              tick_enable_q, tick_enable_d;
  logic              note_on_q, note_on_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;
  logic              advance;
  logic              entry_end;

  assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur  = rom_data[DUR_W-1:0];
  assign advance  = tick_32 & ~pause;

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    note_d     = note_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    entry_end  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (play && !stop) begin
          state_d    = S_FETCH;
          rom_addr_d = '0;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_dur == '0) begin
          state_d = S_DONE;
        end else begin
          note_d    = rom_note;
          dur_cnt_d = rom_dur;
          state_d   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (advance) begin
          dur_cnt_d = dur_cnt_q - DUR_ONE;
          if (dur_cnt_q == DUR_ONE) begin
            if (GAP_TICKS == 0) begin
              entry_end = 1'b1;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = GAP_INIT;
            end
          end
        end
      end
      S_GAP: begin
        if (advance) begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
          if (gap_cnt_q == GAP_ONE) entry_end = 1'b1;
        end
      end
      S_DONE: begin
        note_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The song never wraps: running off the top of the ROM ends it.
    if (entry_end) begin
      if (rom_addr_q == LAST_ADDR) begin
        state_d = S_DONE;
      end else begin
        rom_addr_d = rom_addr_q + ADDR_ONE;
        state_d    = S_FETCH;
      end
    end

    if (stop && state_q != S_IDLE) begin
      state_d    = S_IDLE;
      rom_addr_d = '0;
      note_d     = '0;
      dur_cnt_d  = '0;
      gap_cnt_d  = '0;
    end

    // Outputs are registered alongside the state they describe.
    tick_enable_d = (state_d == S_PLAY || state_d == S_GAP) && !pause;
    note_on_d     = tick_enable_d && (state_d == S_PLAY) && (note_d != '0);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rom_addr_q    <= '0;
      note_q        <= '0;
      dur_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      tick_enable_q <= 1'b0;
      note_on_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      note_q        <= note_d;
      dur_cnt_q     <= dur_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      tick_enable_q <= tick_enable_d;
      note_on_q     <= note_on_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign tick_enable = tick_enable_q;
  assign rom_addr    = rom_addr_q;
  assign note        = note_q;
  assign note_on     = note_on_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_music_box_sequencer.sv
`default_nettype none
// tb_music_box_sequencer: three differently configured sequencers share one
// stimulus stream and are compared every cycle against a song-level model.
module tb_music_box_sequencer;
  localparam int NK = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, play, pause, stop, tick;
  logic [10:0] rom0 [256];
  logic [10:0] rom1 [256];
  logic [10:0] rom2 [4];
  logic [10:0] rd   [NK];
  logic [7:0]  addr0, addr1;
  logic [1:0]  addr2;
  logic [7:0]  da   [NK];
  logic [4:0]  dn   [NK];
  logic        don  [NK];
  logic        dte  [NK];
  logic        dbusy[NK];
  logic        ddone[NK];

  int checks = 0;
  int failures = 0;

  assign da[0] = addr0;
  assign da[1] = addr1;
  assign da[2] = {6'b0, addr2};

  always @(posedge clock) begin
    rd[0] <= rom0[addr0];
    rd[1] <= rom1[addr1];
    rd[2] <= rom2[addr2];
  end

  music_box_sequencer #(.ADDR_W(8), .NOTE_W(5), .DUR_W(6), .GAP_TICKS(0)) u0 (
    .clock(clock), .reset(reset), .play(play), .pause(pause), .stop(stop),
    .tick_32(tick), .tick_enable(dte[0]), .rom_addr(addr0), .rom_data(rd[0]),
    .note(dn[0]), .note_on(don[0]), .busy(dbusy[0]), .done(ddone[0]));
  music_box_sequencer #(.ADDR_W(8), .NOTE_W(5), .DUR_W(6), .GAP_TICKS(2)) u1 (
    .clock(clock), .reset(reset), .play(play), .pause(pause), .stop(stop),
    .tick_32(tick), .tick_enable(dte[1]), .rom_addr(addr1), .rom_data(rd[1]),
    .note(dn[1]), .note_on(don[1]), .busy(dbusy[1]), .done(ddone[1]));
  music_box_sequencer #(.ADDR_W(2), .NOTE_W(5), .DUR_W(6), .GAP_TICKS(1)) u2 (
    .clock(clock), .reset(reset), .play(play), .pause(pause), .stop(stop),
    .tick_32(tick), .tick_enable(dte[2]), .rom_addr(addr2), .rom_data(rd[2]),
    .note(dn[2]), .note_on(don[2]), .busy(dbusy[2]), .done(ddone[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- song-level reference model ----------------
  int gap_cfg [NK] = '{0, 2, 1};
  int last_cfg[NK] = '{255, 255, 3};
  int m_active[NK], m_fetch[NK], m_gap[NK], m_left[NK];
  int m_idx[NK], m_note[NK], m_end[NK], m_pz[NK];
  logic [10:0] m_e;

  function automatic logic [10:0] rom_at(input int k, input int i);
    if (k == 0) return rom0[i[7:0]];
    else if (k == 1) return rom1[i[7:0]];
    else return rom2[i[1:0]];
  endfunction

  // m_fetch counts cycles still needed before the current entry is loaded.
  always @(posedge clock) begin
    for (int k = 0; k < NK; k++) begin
      m_pz[k] = pause ? 1 : 0;
      if (!reset || (m_active[k] != 0 && stop)) begin
        m_active[k] = 0; m_fetch[k] = 0; m_gap[k] = 0; m_left[k] = 0;
        m_idx[k] = 0; m_note[k] = 0; m_end[k] = 0;
      end else if (m_active[k] == 0) begin
        if (play && !stop) begin
          m_active[k] = 1; m_idx[k] = 0; m_fetch[k] = 2; m_gap[k] = 0; m_end[k] = 0;
        end
      end else if (m_end[k] != 0) begin
        m_active[k] = 0; m_end[k] = 0; m_note[k] = 0;
      end else if (m_fetch[k] == 2) begin
        m_fetch[k] = 1;
      end else if (m_fetch[k] == 1) begin
        m_e = rom_at(k, m_idx[k]);
        m_fetch[k] = 0;
        m_gap[k] = 0;
        if (m_e[5:0] == 6'd0) m_end[k] = 1;
        else begin
          m_note[k] = int'(m_e[10:6]);
          m_left[k] = int'(m_e[5:0]);
        end
      end else if (!pause && tick) begin
        m_left[k] = m_left[k] - 1;
        if (m_left[k] == 0) begin
          if (m_gap[k] == 0 && gap_cfg[k] > 0) begin
            m_gap[k] = 1; m_left[k] = gap_cfg[k];
          end else if (m_idx[k] == last_cfg[k]) begin
            m_end[k] = 1;
          end else begin
            m_idx[k] = m_idx[k] + 1; m_fetch[k] = 2;
          end
        end
      end
    end
  end

  function automatic logic exp_te(input int k);
    return m_active[k] != 0 && m_end[k] == 0 && m_fetch[k] == 0 && m_pz[k] == 0;
  endfunction

  always @(posedge clock) begin
    #1;
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("busy%0d", k), {31'b0, dbusy[k]}, {31'b0, m_active[k] != 0});
      chk($sformatf("done%0d", k), {31'b0, ddone[k]}, {31'b0, m_active[k] != 0 && m_end[k] != 0});
      chk($sformatf("tick_enable%0d", k), {31'b0, dte[k]}, {31'b0, exp_te(k)});
      chk($sformatf("note_on%0d", k), {31'b0, don[k]},
          {31'b0, exp_te(k) && m_gap[k] == 0 && m_note[k] != 0});
      chk($sformatf("note%0d", k), {27'b0, dn[k]}, m_note[k]);
      chk($sformatf("rom_addr%0d", k), {24'b0, da[k]}, m_idx[k]);
    end
  end

  // ---------------- event counters observed on the DUT pins ----------------
  int done_cnt[NK], snd[NK], rest[NK];
  int snd0[32];
  int addr2_done = -1;

  always @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < NK; k++) begin
        if (ddone[k]) done_cnt[k]++;
        if (tick && !pause && don[k]) snd[k]++;
        if (tick && !pause && dte[k] && !don[k]) rest[k]++;
      end
      if (tick && !pause && don[0]) snd0[dn[0]]++;
      if (ddone[2]) addr2_done = int'(addr2);
    end
  end

  // Drives one cycle's inputs, then returns just after the edge that samples them.
  task automatic cyc(input logic p, input logic pz, input logic s, input logic t, input logic r);
    @(negedge clock);
    play = p; pause = pz; stop = s; tick = t; reset = r;
    @(posedge clock);
    #2;
  endtask

  task automatic tk(input logic pz);
    cyc(1'b0, pz, 1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, pz, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  int b_a, b_b, b_c, b_d, b_e, b_f, b_g, b_h, b_i, b_j;
  logic pz_r;

  initial begin
    reset = 1'b0; play = 1'b0; pause = 1'b0; stop = 1'b0; tick = 1'b0;
    for (int i = 0; i < 256; i++) begin rom0[i] = '0; rom1[i] = '0; end
    rom0[0] = {5'd3, 6'd2}; rom0[1] = {5'd7, 6'd1};
    rom1[0] = {5'd9, 6'd3};
    for (int i = 0; i < 4; i++) rom2[i] = {5'd1, 6'd1};

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_busy", {31'b0, dbusy[0]}, 32'd0);
    chk("reset_addr", {24'b0, addr0}, 32'd0);
    idle(1);

    // Two-note song with no gap, plus gap and no-end-marker configs alongside.
    b_a = snd0[3]; b_b = snd0[7]; b_c = done_cnt[0];
    b_d = snd[1]; b_e = rest[1]; b_f = done_cnt[1];
    b_g = snd[2]; b_h = rest[2]; b_i = done_cnt[2];
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("s1_busy_cycle1", {31'b0, dbusy[0]}, 32'd1);
    idle(1);
    idle(1);
    chk("s1_note_on_cycle3", {31'b0, don[0]}, 32'd1);
    chk("s1_note_cycle3", {27'b0, dn[0]}, 32'd3);
    repeat (20) tk(1'b0);
    idle(5);
    chk("s1_note3_ticks", snd0[3] - b_a, 32'd2);
    chk("s1_note7_ticks", snd0[7] - b_b, 32'd1);
    chk("s1_done0", done_cnt[0] - b_c, 32'd1);
    chk("s1_busy0_end", {31'b0, dbusy[0]}, 32'd0);
    chk("s1_gap_sound_ticks", snd[1] - b_d, 32'd3);
    chk("s1_gap_silent_ticks", rest[1] - b_e, 32'd2);
    chk("s1_done1", done_cnt[1] - b_f, 32'd1);
    chk("s1_nowrap_sound", snd[2] - b_g, 32'd4);
    chk("s1_nowrap_gaps", rest[2] - b_h, 32'd4);
    chk("s1_nowrap_done", done_cnt[2] - b_i, 32'd1);
    chk("s1_nowrap_addr", addr2_done, 32'd3);
    chk("s1_nowrap_busy", {31'b0, dbusy[2]}, 32'd0);

    // Rest entry sounds nothing but still counts ticks.
    rom0[0] = {5'd0, 6'd4}; rom0[1] = {5'd5, 6'd1}; rom0[2] = '0;
    b_a = rest[0]; b_b = snd0[5]; b_c = done_cnt[0];
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("s2_rest_note_on", {31'b0, don[0]}, 32'd0);
    chk("s2_rest_tick_enable", {31'b0, dte[0]}, 32'd1);
    repeat (20) tk(1'b0);
    idle(5);
    chk("s2_rest_ticks", rest[0] - b_a, 32'd4);
    chk("s2_note5_ticks", snd0[5] - b_b, 32'd1);
    chk("s2_done", done_cnt[0] - b_c, 32'd1);

    // Pause after the first of three ticks; paused ticks must not count.
    rom0[0] = {5'd4, 6'd3}; rom0[1] = '0;
    b_a = snd0[4]; b_b = done_cnt[0];
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    tk(1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) tk(1'b1);
    chk("s3_paused_te", {31'b0, dte[0]}, 32'd0);
    chk("s3_paused_on", {31'b0, don[0]}, 32'd0);
    chk("s3_paused_note", {27'b0, dn[0]}, 32'd4);
    idle(2);
    tk(1'b0);
    chk("s3_resumed_on", {31'b0, don[0]}, 32'd1);
    tk(1'b0);
    idle(6);
    chk("s3_note4_ticks", snd0[4] - b_a, 32'd3);
    chk("s3_done", done_cnt[0] - b_b, 32'd1);

    // Stop mid-note with play held.
    rom0[0] = {5'd6, 6'd5};
    b_a = done_cnt[0];
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("s4_stop_busy", {31'b0, dbusy[0]}, 32'd0);
    chk("s4_stop_note", {27'b0, dn[0]}, 32'd0);
    chk("s4_stop_on", {31'b0, don[0]}, 32'd0);
    repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    chk("s4_no_restart", {31'b0, dbusy[0]}, 32'd0);
    chk("s4_no_done", done_cnt[0] - b_a, 32'd0);

    // Reset mid-note clears every output at the next edge.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(4);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("s5_rst_busy%0d", k), {31'b0, dbusy[k]}, 32'd0);
      chk($sformatf("s5_rst_note%0d", k), {27'b0, dn[k]}, 32'd0);
      chk($sformatf("s5_rst_addr%0d", k), {24'b0, da[k]}, 32'd0);
    end
    idle(2);

    // Randomized songs and control traffic.
    for (int i = 0; i < 256; i++) begin
      b_j = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3));
      rom0[i] = {5'($urandom_range(0, 31)), 6'(b_j)};
      b_j = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 3));
      rom1[i] = {5'($urandom_range(0, 31)), 6'(b_j)};
    end
    for (int i = 0; i < 4; i++) rom2[i] = {5'($urandom_range(0, 3)), 6'($urandom_range(1, 2))};
    pz_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) pz_r = ~pz_r;
      cyc(($urandom_range(0, 19) == 0), pz_r, ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 299) != 0));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
